// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one operand bit per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_c;
  logic             ps;
  logic             pc;
  logic             last;

  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load = b;
  assign c_load = 1'b0;
`endif

  // full-adder slice built from two half adders on the current bit
  assign ha1_s = a_sr[0] ^ b_sr[0];
  assign ha1_c = a_sr[0] & b_sr[0];
  assign ha2_c = ha1_s & carry;
  assign ps    = ha1_s ^ carry;
  assign pc    = ha1_c | ha2_c;

  assign last  = (cnt == CW'(WIDTH - 1));

  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // operand capture, serial add and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            cnt   <= '0;
            carry <= c_load;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= {ps, r_sr[WIDTH-1:1]};
          carry <= pc;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= {ps, r_sr[WIDTH-1:1]};
            cout <= pc;
            ovf  <= carry ^ pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8).
// Expected results are queued at START and retired on each DONE pulse.
module tb_serial_adder;

  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s);
    exp_t e;
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         cin;
    cin  = SUB_EN && s;
    yy   = cin ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (W+1)'(cin);
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // retire one expected result per DONE pulse
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      dones++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: DONE with empty scoreboard, sum=%h", sum);
      end else begin
        e = sb.pop_front();
        if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
          errors++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e.s, e.c, e.o);
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input bit push);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    sub = s;
    if (push) sb.push_back(model(x, y, s));
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results pending, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    start = 1'b1;
    a = 8'h11;
    b = 8'h22;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: got busy=%b, want 0", busy);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_dropped: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_timing();
    int d0;
    d0 = dones;
    drive(8'h05, 8'h03, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL busy_window[%0d]: got busy=%b done=%b, want busy=1 done=0",
                 i, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL done_pulse: got busy=%b done=%b, want busy=0 done=1", busy, done);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || dones != d0 + 1) begin
      errors++;
      $display("FAIL after_done: got busy=%b done=%b dones=%0d, want 0 0 %0d",
               busy, done, dones - d0, 1);
    end
    wait_empty();
  endtask

  task automatic test_add();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    xs = '{8'hFF, 8'h7F, 8'h80, 8'hA5};
    ys = '{8'h01, 8'h01, 8'h80, 8'h5A};
    for (int i = 0; i < 4; i++) begin
      drive(xs[i], ys[i], 1'b0, 1'b1);
      wait_empty();
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_empty();
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    exp_t e1;
    d0 = dones;
    @(negedge clk);
    start = 1'b1;
    a = 8'h3C;
    b = 8'h0F;
    sub = 1'b0;
    e1 = model(8'h3C, 8'h0F, 1'b0);
    sb.push_back(e1);
    for (int n = 0; n <= 2 * W + 3; n++) begin
      @(negedge clk);
      if (n == W + 1) begin
        a = 8'h21;
        b = 8'h43;
        sb.push_back(model(8'h21, 8'h43, 1'b0));
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if (n == 2 * W + 1) begin
        checks++;
        if (sum !== e1.s) begin
          errors++;
          $display("FAIL sum_hold: got sum=%h, want %h", sum, e1.s);
        end
      end
      if (n == 2 * W + 3) start = 1'b0;
    end
    repeat (W + 4) @(negedge clk);
    checks++;
    if (dones != d0 + 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL held_start: got %0d dones %0d pending, want 2 dones 0 pending",
               dones - d0, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    drive(8'h55, 8'h66, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = dones;
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    repeat (W + 3) @(negedge clk);
    checks++;
    if (dones != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL aborted_done: got %0d dones busy=%b, want 0 dones busy=0",
               dones - d0, busy);
    end
    drive(8'h10, 8'h20, 1'b0, 1'b1);
    wait_empty();
  endtask

  task automatic test_sub();
    drive(8'h05, 8'h07, 1'b1, 1'b1);
    wait_empty();
    drive(8'h80, 8'h01, 1'b1, 1'b1);
    wait_empty();
    drive(8'h07, 8'h05, 1'b1, 1'b1);
    wait_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_add();
    test_back_to_back();
    test_reset_mid();
    test_sub();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder for the ALU, placed directly downstream of the half-adder cell. It chains two half-adder equivalents and a carry flip-flop into one full-adder slice, and processes one operand bit per clock, LSB first. A START/BUSY/DONE handshake gives parallel operands in and a parallel result out. It is the area-lean alternative to the ripple-carry adder.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous reset, active-high
- START  input  1  request an operation; sampled only in IDLE
- A  input  WIDTH  operand A; captured on an accepted START
- B  input  WIDTH  operand B; captured on an accepted START
- SUB  input  1  subtract request; captured on START; ignored unless SERIAL_ADDER_SUB_EN
- BUSY  output  1  high while in RUN
- DONE  output  1  one-cycle pulse; result valid
- SUM  output  WIDTH  registered result
- COUT  output  1  carry out of the MSB
- OVF  output  1  signed overflow: carry into the MSB XOR carry out of the MSB

## Operation
- One clock domain; reset is synchronous and active-high.
- State machine with three states:
  - IDLE: if START=1, capture A and B into right-shift registers, clear the bit counter, load the carry FF with 0 (or 1, see Configuration), go to RUN. If START=0, stay in IDLE.
  - RUN: each cycle, take a and b as bit 0 of the shift registers and c as the carry FF.
    - Partial sum s = a^b^c; carry c' = (a&b)|(c&(a^b)).
    - Shift s into the MSB of the result shift register; shift both operand registers right by one; carry FF <= c'; counter increments.
    - On the cycle where counter = WIDTH-1: load SUM from the completed result, COUT <= c', OVF <= c^c', go to DONE.
  - DONE: DONE=1 for this one cycle, then unconditionally go to IDLE.
- BUSY = (state==RUN); DONE = (state==DONE). Both are registered state decodes.
- START is ignored in RUN and DONE. No queuing of requests.
- SUM, COUT and OVF change only on completion. They hold their values until the next completion or reset.
- Operands are unsigned for COUT and two's-complement for OVF. Results wrap modulo 2^WIDTH.
- Reset values: state IDLE, BUSY 0, DONE 0, SUM 0, COUT 0, OVF 0, internal shift registers, counter and carry FF 0.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. The aborted operation produces no DONE pulse.
- RST and START asserted together: reset wins and START is dropped.

## Timing
- START sampled high in IDLE at edge T.
- BUSY is high for edges T+1 through T+WIDTH, exactly WIDTH cycles.
- DONE is high after edge T+WIDTH+1; SUM, COUT and OVF are valid from that point.
- IDLE after edge T+WIDTH+2. The earliest next START is accepted at that edge.
- Throughput: one operation per WIDTH+2 cycles.
- No combinational path from any input to any output.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - SUB is captured on START.
  - If SUB=1, ~B is loaded into the B shift register and the carry FF is initialised to 1, so SUM = A-B mod 2^WIDTH.
  - In subtract mode, COUT=1 means no borrow (A≥B unsigned).
  - OVF is the signed-subtraction overflow.
- SERIAL_ADDER_SUB_EN undefined:
  - The SUB port is still present but ignored.
  - Every operation is A+B with carry-in 0.

## Test plan
Default WIDTH=8 for all scenarios.
- Reset, then START with A=8'h05, B=8'h03 → BUSY high for 8 cycles, DONE pulse at T+9, SUM=8'h08, COUT=0, OVF=0.
- A=8'hFF, B=8'h01 → SUM=8'h00, COUT=1, OVF=0. A=8'h7F, B=8'h01 → SUM=8'h80, COUT=0, OVF=1. A=8'h80, B=8'h80 → SUM=8'h00, COUT=1, OVF=1.
- START held high continuously with operands changed during RUN → first operands' result only, exactly one DONE pulse per WIDTH+2 cycles, next START accepted only in IDLE; SUM holds between DONEs.
- RST asserted at the 4th RUN cycle → next cycle BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0, no DONE pulse; a following START with A=8'h10, B=8'h20 gives SUM=8'h30.
- With SERIAL_ADDER_SUB_EN: SUB=1, A=8'h05, B=8'h07 → SUM=8'hFE, COUT=0, OVF=0; SUB=1, A=8'h80, B=8'h01 → SUM=8'h7F, COUT=1, OVF=1. Without the macro: SUB=1, A=8'h05, B=8'h07 → SUM=8'h0C.
